// File: rtl/reg_dst_scheduler.sv
// Destination-register tracker for the EX/MEM/WB stages: load-use stall, EX forwarding selects, WB write port.
// Stall and forwarding are combinational; entries advance one stage per edge and freeze entirely on i_mem_wait.
module reg_dst_scheduler #(
  parameter int NBITS = 5,
  parameter int NCNT  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_id_valid,
  input  logic [NBITS-1:0] i_rs,
  input  logic [NBITS-1:0] i_rt,
  input  logic [NBITS-1:0] i_rd,
  input  logic             i_use_rs,
  input  logic             i_use_rt,
  input  logic             i_RegDst,
  input  logic             i_RegWrite,
  input  logic             i_MemRead,
  input  logic             i_flush,
  input  logic             i_mem_wait,
  output logic             o_stall,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [NBITS-1:0] o_dst_mem,
  output logic             o_wb_we,
  output logic [NBITS-1:0] o_wb_addr,
  output logic [NCNT-1:0]  o_stall_count
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             is_load;
    logic [NBITS-1:0] dst;
  } stage_t;

  typedef struct packed {
    logic [NBITS-1:0] rs;
    logic [NBITS-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } src_t;

  stage_t           ex_q, mem_q, wb_q;
  src_t             ex_src_q;
  stage_t           id_ent;
  src_t             id_src;
  logic [NBITS-1:0] wb_addr_q;
  logic [NCNT-1:0]  cnt_q;
  logic             load_use;
  logic             stall_evt;

  // An empty decode slot enters EX as an all-zero bubble so it can never match or forward.
  always_comb begin
    id_ent = '0;
    id_src = '0;
    if (i_id_valid) begin
      id_ent.valid    = 1'b1;
      id_ent.dst      = i_RegDst ? i_rd : i_rt;
      id_ent.regwrite = i_RegWrite & (id_ent.dst != '0);
      id_ent.is_load  = i_MemRead;
      id_src.rs       = i_rs;
      id_src.rt       = i_rt;
      id_src.use_rs   = i_use_rs;
      id_src.use_rt   = i_use_rt;
    end
  end

  assign load_use = ex_q.valid & ex_q.is_load & ex_q.regwrite & i_id_valid &
                    (((ex_q.dst == i_rs) & i_use_rs) | ((ex_q.dst == i_rt) & i_use_rt));
  assign stall_evt = load_use | i_mem_wait;

  // Gated by reset so every output reads zero while reset is held.
  assign o_stall = i_reset & stall_evt;

  function automatic logic [1:0] fwd_sel(input logic [NBITS-1:0] src, input logic use_src,
                                         input stage_t mem_e, input stage_t wb_e);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && (src != '0)) begin
      if (mem_e.valid && mem_e.regwrite && !mem_e.is_load && (mem_e.dst == src))
        sel = 2'b10;
      else if (wb_e.valid && wb_e.regwrite && (wb_e.dst == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign o_fwd_a = fwd_sel(ex_src_q.rs, ex_src_q.use_rs, mem_q, wb_q);
  assign o_fwd_b = fwd_sel(ex_src_q.rt, ex_src_q.use_rt, mem_q, wb_q);

  assign o_dst_mem     = mem_q.dst;
  assign o_wb_we       = wb_q.valid & wb_q.regwrite & ~i_mem_wait;
  assign o_wb_addr     = o_wb_we ? wb_q.dst : wb_addr_q;
  assign o_stall_count = cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ex_q      <= '0;
      ex_src_q  <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      wb_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (o_wb_we)
        wb_addr_q <= wb_q.dst;
      if (stall_evt && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
      // Flush coinciding with load_use still bubbles EX; the branch unit re-flushes after the stall.
      if (!i_mem_wait) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        if (load_use || i_flush) begin
          ex_q     <= '0;
          ex_src_q <= '0;
        end else begin
          ex_q     <= id_ent;
          ex_src_q <= id_src;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_dst_scheduler.sv
// Bench for reg_dst_scheduler: directed scenarios plus random traffic, all outputs compared every cycle
// against an instruction-level pipeline model.
module tb_reg_dst_scheduler;
  localparam int NB = 5;
  localparam int NC = 4;
  localparam int CMAX = (1 << NC) - 1;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_id_valid;
  logic [NB-1:0] i_rs, i_rt, i_rd;
  logic          i_use_rs, i_use_rt, i_RegDst, i_RegWrite, i_MemRead, i_flush, i_mem_wait;
  logic          o_stall;
  logic [1:0]    o_fwd_a, o_fwd_b;
  logic [NB-1:0] o_dst_mem;
  logic          o_wb_we;
  logic [NB-1:0] o_wb_addr;
  logic [NC-1:0] o_stall_count;

  reg_dst_scheduler #(.NBITS(NB), .NCNT(NC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
    .i_RegDst(i_RegDst), .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead),
    .i_flush(i_flush), .i_mem_wait(i_mem_wait),
    .o_stall(o_stall), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_dst_mem(o_dst_mem),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_stall_count(o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one record per in-flight instruction, indexed by pipeline stage.
  typedef struct {
    bit v, w, ld, urs, urt;
    int dst, rs, rt;
  } ent_t;

  ent_t m_ex, m_mem, m_wb;
  int   m_last, m_cnt;

  function automatic ent_t empty_ent();
    ent_t e;
    e = '{default: 0};
    return e;
  endfunction

  task automatic model_reset();
    m_ex = empty_ent(); m_mem = empty_ent(); m_wb = empty_ent();
    m_last = 0; m_cnt = 0;
  endtask

  function automatic bit m_lu();
    return m_ex.v && m_ex.ld && m_ex.w && (i_id_valid == 1'b1) &&
           ((m_ex.dst == int'(i_rs) && i_use_rs) || (m_ex.dst == int'(i_rt) && i_use_rt));
  endfunction

  function automatic int m_fwd(int src, bit u);
    if (!m_ex.v || !u || src == 0) return 0;
    if (m_mem.v && m_mem.w && !m_mem.ld && m_mem.dst == src) return 2;
    if (m_wb.v && m_wb.w && m_wb.dst == src) return 1;
    return 0;
  endfunction

  function automatic bit m_we();
    return m_wb.v && m_wb.w && !i_mem_wait;
  endfunction

  task automatic compare_all();
    check("stall", o_stall, (i_reset && (m_lu() || i_mem_wait)) ? 1 : 0);
    check("fwd_a", o_fwd_a, m_fwd(m_ex.rs, m_ex.urs));
    check("fwd_b", o_fwd_b, m_fwd(m_ex.rt, m_ex.urt));
    check("dst_mem", o_dst_mem, m_mem.v ? m_mem.dst : 0);
    check("wb_we", o_wb_we, m_we());
    check("wb_addr", o_wb_addr, m_we() ? m_wb.dst : m_last);
    check("stall_count", o_stall_count, m_cnt);
  endtask

  task automatic model_update();
    bit lu;
    ent_t n;
    if (!i_reset) begin
      model_reset();
      return;
    end
    lu = m_lu();
    if (m_we()) m_last = m_wb.dst;
    if ((lu || i_mem_wait) && m_cnt < CMAX) m_cnt++;
    if (i_mem_wait) return;
    n = empty_ent();
    if (!lu && !i_flush && i_id_valid) begin
      n.v = 1; n.dst = i_RegDst ? int'(i_rd) : int'(i_rt);
      n.w = i_RegWrite && n.dst != 0; n.ld = i_MemRead;
      n.rs = i_rs; n.rt = i_rt; n.urs = i_use_rs; n.urt = i_use_rt;
    end
    m_wb = m_mem; m_mem = m_ex; m_ex = n;
  endtask

  task automatic cycle();
    @(negedge i_clk);
    compare_all();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    i_id_valid = 0; i_rs = 0; i_rt = 0; i_rd = 0; i_use_rs = 0; i_use_rt = 0;
    i_RegDst = 0; i_RegWrite = 0; i_MemRead = 0; i_flush = 0; i_mem_wait = 0;
  endtask

  task automatic issue(input int rs, input int rt, input int rd, input bit urs, input bit urt,
                       input bit regdst, input bit rw, input bit mr);
    i_id_valid = 1; i_rs = NB'(rs); i_rt = NB'(rt); i_rd = NB'(rd);
    i_use_rs = urs; i_use_rt = urt; i_RegDst = regdst; i_RegWrite = rw; i_MemRead = mr;
    i_flush = 0; i_mem_wait = 0;
  endtask

  task automatic rand_in(input bit allow_wait);
    i_id_valid = ($urandom_range(0, 3) != 0);
    i_rs = NB'($urandom_range(0, 7)); i_rt = NB'($urandom_range(0, 7)); i_rd = NB'($urandom_range(0, 7));
    i_use_rs = 1'($urandom); i_use_rt = 1'($urandom); i_RegDst = 1'($urandom);
    i_RegWrite = ($urandom_range(0, 3) != 0); i_MemRead = ($urandom_range(0, 2) == 0);
    i_flush = ($urandom_range(0, 9) == 0);
    i_mem_wait = allow_wait && ($urandom_range(0, 9) == 0);
  endtask

  int wb_pulses = 0;
  bit seen7 = 0;
  always @(negedge i_clk) begin
    if (o_wb_we === 1'b1) wb_pulses++;
    if (o_dst_mem == 7 || o_wb_addr == 7) seen7 = 1;
  end

  initial begin
    int p0, c0;
    model_reset();
    i_reset = 0;
    rand_in(1);
    i_mem_wait = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_in(1);
      cycle();
    end
    rand_in(1);
    i_mem_wait = 1;
    #1;
    check("rst_stall", o_stall, 0);
    check("rst_fwd_a", o_fwd_a, 0);
    check("rst_wb_we", o_wb_we, 0);
    check("rst_wb_addr", o_wb_addr, 0);
    check("rst_count", o_stall_count, 0);
    i_reset = 1;
    idle();
    for (int i = 0; i < 3; i++) cycle();
    check("idle_wb_we", o_wb_we, 0);

    // RegDst=1 picks rd, RegDst=0 picks rt, rd=0 never writes.
    issue(0, 9, 5, 0, 0, 1, 1, 0); cycle();
    idle(); cycle(); #1;
    check("regdst1_mem", o_dst_mem, 5);
    cycle(); #1;
    check("regdst1_we", o_wb_we, 1);
    check("regdst1_addr", o_wb_addr, 5);
    cycle(); cycle();
    issue(0, 9, 5, 0, 0, 0, 1, 0); cycle();
    idle(); cycle(); #1;
    check("regdst0_mem", o_dst_mem, 9);
    cycle(); #1;
    check("regdst0_addr", o_wb_addr, 9);
    cycle(); cycle();
    issue(0, 9, 0, 0, 0, 1, 1, 0); cycle();
    idle(); cycle(); cycle(); #1;
    check("rd0_we", o_wb_we, 0);
    cycle(); cycle();

    // Load-use: one stall, then WB forwarding to the consumer.
    issue(1, 8, 0, 1, 0, 0, 1, 1); cycle();
    issue(8, 2, 10, 1, 1, 1, 1, 0); #1;
    check("lu_stall_on", o_stall, 1);
    cycle(); #1;
    check("lu_stall_off", o_stall, 0);
    check("lu_count", o_stall_count, 1);
    cycle();
    idle(); #1;
    check("lu_fwd_a", o_fwd_a, 1);
    check("lu_fwd_b", o_fwd_b, 0);
    cycle(); cycle(); cycle();

    // ALU forwarding from MEM, then from WB with a spacer.
    issue(0, 0, 3, 0, 0, 1, 1, 0); cycle();
    issue(3, 3, 4, 1, 1, 1, 1, 0); cycle();
    idle(); #1;
    check("alu_mem_a", o_fwd_a, 2);
    check("alu_mem_b", o_fwd_b, 2);
    cycle(); cycle(); cycle();
    issue(0, 0, 3, 0, 0, 1, 1, 0); cycle();
    issue(1, 2, 4, 1, 1, 1, 1, 0); cycle();
    issue(3, 3, 5, 1, 1, 1, 1, 0); cycle();
    idle(); #1;
    check("alu_wb_a", o_fwd_a, 1);
    check("alu_wb_b", o_fwd_b, 1);
    cycle(); cycle(); cycle();

    // Memory wait freezes three in-flight writes; all three retire afterwards.
    issue(0, 0, 11, 0, 0, 1, 1, 0); cycle();
    issue(0, 0, 12, 0, 0, 1, 1, 0); cycle();
    issue(0, 0, 13, 0, 0, 1, 1, 0); cycle();
    idle();
    i_mem_wait = 1;
    p0 = wb_pulses;
    #1;
    check("mw_stall", o_stall, 1);
    check("mw_we", o_wb_we, 0);
    check("mw_mem_pre", o_dst_mem, 12);
    cycle(); cycle(); cycle(); #1;
    check("mw_count", o_stall_count, 4);
    check("mw_mem_post", o_dst_mem, 12);
    i_mem_wait = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("mw_writes", wb_pulses - p0, 3);

    // Flushed write of r7 never becomes visible.
    seen7 = 0;
    c0 = int'(o_stall_count);
    issue(0, 0, 7, 0, 0, 1, 1, 0);
    i_flush = 1;
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();
    check("flush_seen7", seen7, 0);
    check("flush_count", o_stall_count, c0);

    for (int i = 0; i < 600; i++) begin
      rand_in(1);
      cycle();
    end
    idle(); #1;
    check("cnt_saturated", o_stall_count, CMAX);

    // Reset in the middle of a memory-wait stall.
    issue(0, 0, 6, 0, 0, 1, 1, 0); cycle();
    idle(); i_mem_wait = 1; cycle();
    i_reset = 0;
    model_reset();
    #1;
    check("midrst_stall", o_stall, 0);
    check("midrst_count", o_stall_count, 0);
    check("midrst_mem", o_dst_mem, 0);
    check("midrst_we", o_wb_we, 0);
    cycle();
    i_reset = 1;
    idle();
    for (int i = 0; i < 3; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
